brick_draw_engine: RTL and testbench



---
 rtl/breakout_pkg.sv | 14 +
 rtl/brick_pixel_counter.sv | 37 +++
 rtl/brick_draw_engine.sv | 80 ++++++++
 tb/tb_brick_draw_engine.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/breakout_pkg.sv
// breakout_pkg: shared screen geometry, brick_in field layout and draw-engine state encoding
package breakout_pkg;
  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int COLOUR_W = 3;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int COLOUR_LSB = 0;
  localparam int Y_LSB = COLOUR_LSB + COLOUR_W;
  localparam int ALIVE_BIT = Y_LSB + Y_W;
  localparam int X_LSB = ALIVE_BIT + 1;
  localparam int BRICK_IN_W = X_LSB + X_W;
  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} draw_state_e;
endpackage

// File: rtl/brick_pixel_counter.sv
// brick_pixel_counter: raster-order cx/cy sweep over a BRICK_W x BRICK_H rectangle
module brick_pixel_counter #(
  parameter int BRICK_W = 16,
  parameter int BRICK_H = 4,
  parameter int CX_W = BRICK_W > 1 ? $clog2(BRICK_W) : 1,
  parameter int CY_W = BRICK_H > 1 ? $clog2(BRICK_H) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            enable,
  output logic [CX_W-1:0] cx,
  output logic [CY_W-1:0] cy,
  output logic            last
);
  import breakout_pkg::*;
  localparam logic [CX_W-1:0] CX_MAX = CX_W'(BRICK_W - 1);
  localparam logic [CY_W-1:0] CY_MAX = CY_W'(BRICK_H - 1);
  logic [CX_W-1:0] cx_d;
  logic [CY_W-1:0] cy_d;
  logic wrap;
  assign wrap = cx == CX_MAX;
  assign last = wrap && cy == CY_MAX;
  always_comb begin
    cx_d = clear ? '0 : enable ? (wrap ? '0 : cx + 1'b1) : cx;
    cy_d = clear ? '0 : (enable && wrap) ? (last ? '0 : cy + 1'b1) : cy;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cx <= '0;
      cy <= '0;
    end else begin
      cx <= cx_d;
      cy <= cy_d;
    end
  end
endmodule

// File: rtl/brick_draw_engine.sv
// brick_draw_engine: sweeps one brick into per-pixel VGA writes, clipped to the visible screen
module brick_draw_engine #(
  parameter int BRICK_W = 16,
  parameter int BRICK_H = 4,
  parameter int X_W = breakout_pkg::X_W,
  parameter int Y_W = breakout_pkg::Y_W,
  parameter int COLOUR_W = breakout_pkg::COLOUR_W,
  parameter int SCREEN_W = breakout_pkg::SCREEN_W,
  parameter int SCREEN_H = breakout_pkg::SCREEN_H,
  parameter logic [COLOUR_W-1:0] BG_COLOUR = '0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [X_W+Y_W+COLOUR_W:0] brick_in,
  output logic                     busy,
  output logic                     done,
  output logic                     plot,
  output logic [X_W-1:0]           x_out,
  output logic [Y_W-1:0]           y_out,
  output logic [COLOUR_W-1:0]      colour_out
);
  import breakout_pkg::*;
  localparam int CX_W = BRICK_W > 1 ? $clog2(BRICK_W) : 1;
  localparam int CY_W = BRICK_H > 1 ? $clog2(BRICK_H) : 1;
  draw_state_e state_q, state_d;
  logic [X_W-1:0] x_q, in_x;
  logic [Y_W-1:0] y_q, in_y;
  logic [COLOUR_W-1:0] colour_q, in_colour;
  logic alive_q, in_alive;
  logic [CX_W-1:0] cx;
  logic [CY_W-1:0] cy;
  logic last, accept, drawing, visible;
  logic [X_W:0] sum_x;
  logic [Y_W:0] sum_y;
  assign {in_x, in_alive, in_y, in_colour} = brick_in;
  assign accept = state_q == S_IDLE && start;
  assign drawing = state_q == S_DRAW;
  assign busy = drawing;
  // extra carry bit keeps bricks near the right/bottom edge from wrapping back on screen
  assign sum_x = {1'b0, x_q} + (X_W+1)'(cx);
  assign sum_y = {1'b0, y_q} + (Y_W+1)'(cy);
  assign visible = drawing && 32'(sum_x) < SCREEN_W && 32'(sum_y) < SCREEN_H;
  always_comb
    state_d = state_q == S_IDLE ? (start ? S_DRAW : S_IDLE) :
              state_q == S_DRAW ? (last ? S_DONE : S_DRAW) : S_IDLE;
  brick_pixel_counter #(.BRICK_W(BRICK_W), .BRICK_H(BRICK_H)) u_cnt (
    .clk(clock), .rst(reset), .clear(accept), .enable(drawing),
    .cx(cx), .cy(cy), .last(last)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      x_q <= '0;
      y_q <= '0;
      alive_q <= 1'b0;
      colour_q <= '0;
      done <= 1'b0;
      plot <= 1'b0;
      x_out <= '0;
      y_out <= '0;
      colour_out <= '0;
    end else begin
      state_q <= state_d;
      done <= state_q == S_DONE;
      plot <= visible;
      if (accept) begin
        x_q <= in_x;
        y_q <= in_y;
        alive_q <= in_alive;
        colour_q <= in_colour;
      end
      if (visible) begin
        x_out <= sum_x[X_W-1:0];
        y_out <= sum_y[Y_W-1:0];
        colour_out <= alive_q ? colour_q : BG_COLOUR;
      end
    end
  end
endmodule

// File: tb/tb_brick_draw_engine.sv
// tb_brick_draw_engine: random and directed stimulus against a cycle-indexed brick model
module tb_brick_draw_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, start;
  logic [18:0] brick_in;
  logic busy [2], done [2], plot [2];
  logic [7:0] x_out [2];
  logic [6:0] y_out [2];
  logic [2:0] colour_out [2];

  brick_draw_engine dut0 (
    .clock(clk), .reset(reset), .start(start), .brick_in(brick_in),
    .busy(busy[0]), .done(done[0]), .plot(plot[0]),
    .x_out(x_out[0]), .y_out(y_out[0]), .colour_out(colour_out[0])
  );
  brick_draw_engine #(.BRICK_W(1), .BRICK_H(1)) dut1 (
    .clock(clk), .reset(reset), .start(start), .brick_in(brick_in),
    .busy(busy[1]), .done(done[1]), .plot(plot[1]),
    .x_out(x_out[1]), .y_out(y_out[1]), .colour_out(colour_out[1])
  );

  int n_chk = 0, n_fail = 0;
  bit chk_en = 0;
  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, idx, act, exp, $time);
    end
  endtask

  // model: k counts edges since the accepting edge; pixel k-1 is shown after edge k
  int bw [2] = '{16, 1};
  int bh [2] = '{4, 1};
  bit act [2];
  int k [2], mx [2], my [2], mc [2];
  bit mal [2];
  int ex [2], ey [2], ec [2];
  bit eb [2], ed [2], ep [2];
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      automatic int n = bw[i] * bh[i];
      automatic int p, px, py;
      if (reset) begin
        act[i] = 0; ex[i] = 0; ey[i] = 0; ec[i] = 0; eb[i] = 0; ed[i] = 0; ep[i] = 0;
      end else begin
        if (act[i]) k[i]++;
        else if (start) begin
          act[i] = 1; k[i] = 0;
          mx[i] = int'(brick_in[18:11]); mal[i] = brick_in[10];
          my[i] = int'(brick_in[9:3]); mc[i] = int'(brick_in[2:0]);
        end
        eb[i] = 0; ed[i] = 0; ep[i] = 0;
        if (act[i]) begin
          eb[i] = k[i] < n;
          ed[i] = k[i] == n + 1;
          if (k[i] >= 1 && k[i] <= n) begin
            p = k[i] - 1;
            px = mx[i] + p % bw[i];
            py = my[i] + p / bw[i];
            if (px < 160 && py < 120) begin
              ep[i] = 1; ex[i] = px; ey[i] = py; ec[i] = mal[i] ? mc[i] : 0;
            end
          end
          if (ed[i]) act[i] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk("busy", i, 32'(busy[i]), 32'(eb[i]));
        chk("done", i, 32'(done[i]), 32'(ed[i]));
        chk("plot", i, 32'(plot[i]), 32'(ep[i]));
        chk("x_out", i, 32'(x_out[i]), ex[i]);
        chk("y_out", i, 32'(y_out[i]), ey[i]);
        chk("colour_out", i, 32'(colour_out[i]), ec[i]);
      end
    end
  end

  task automatic run(input logic [7:0] x, input logic al, input logic [6:0] y, input logic [2:0] c,
                     input int exp_plots, input int fx, input int fy, input int lx, input int ly,
                     input int ecol, input int restart, input string tag);
    int plots = 0, dones = 0, done_cyc = -1, d1_plots = 0, d1_done = -1;
    int first_x = -1, first_y = -1, last_x = -1, last_y = -1;
    bit col_ok = 1;
    @(negedge clk);
    brick_in = {x, al, y, c};
    start = 1;
    @(negedge clk);
    start = 0;
    for (int cyc = 1; cyc <= 70; cyc++) begin
      if (cyc == restart) begin
        brick_in = 19'($urandom);
        start = 1;
      end else start = 0;
      @(negedge clk);
      if (plot[0]) begin
        plots++;
        if (first_x < 0) begin first_x = int'(x_out[0]); first_y = int'(y_out[0]); end
        last_x = int'(x_out[0]); last_y = int'(y_out[0]);
        if (int'(colour_out[0]) != ecol) col_ok = 0;
      end
      if (done[0]) begin dones++; done_cyc = cyc; end
      if (plot[1]) d1_plots++;
      if (done[1] && d1_done < 0) d1_done = cyc;
    end
    chk({tag, "_plots"}, 0, plots, exp_plots);
    chk({tag, "_first_x"}, 0, first_x, fx);
    chk({tag, "_first_y"}, 0, first_y, fy);
    chk({tag, "_last_x"}, 0, last_x, lx);
    chk({tag, "_last_y"}, 0, last_y, ly);
    chk({tag, "_colour"}, 0, 32'(col_ok), 1);
    chk({tag, "_done_cyc"}, 0, done_cyc, 65);
    chk({tag, "_dones"}, 0, dones, 1);
    if (restart == 0) begin
      chk({tag, "_1x1_plots"}, 1, d1_plots, 1);
      chk({tag, "_1x1_done_cyc"}, 1, d1_done, 2);
    end
  endtask

  initial begin
    int np, nd;
    reset = 1; start = 0; brick_in = '0;
    repeat (2) @(negedge clk);
    chk_en = 1;
    chk("rst_busy", 0, 32'(busy[0]), 0);
    chk("rst_plot", 0, 32'(plot[0]), 0);
    chk("rst_x", 0, 32'(x_out[0]), 0);
    reset = 0;
    run(8'd10, 1'b1, 7'd20, 3'd5, 64, 10, 20, 25, 23, 5, 0, "draw");
    run(8'd10, 1'b0, 7'd20, 3'd5, 64, 10, 20, 25, 23, 0, 0, "erase");
    run(8'd150, 1'b1, 7'd118, 3'd3, 20, 150, 118, 159, 119, 3, 0, "clip");
    run(8'd40, 1'b1, 7'd50, 3'd6, 64, 40, 50, 55, 53, 6, 10, "restart");
    @(negedge clk);
    brick_in = {8'd60, 1'b1, 7'd30, 3'd2};
    start = 1;
    @(negedge clk);
    start = 0;
    np = 0;
    for (int c = 0; c < 40 && np < 30; c++) begin
      @(negedge clk);
      if (plot[0]) np++;
    end
    chk("abort_reach30", 0, np, 30);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("abort_plot", 0, 32'(plot[0]), 0);
    chk("abort_busy", 0, 32'(busy[0]), 0);
    nd = 0;
    repeat (70) begin
      @(negedge clk);
      if (done[0]) nd++;
    end
    chk("abort_no_done", 0, nd, 0);
    run(8'd10, 1'b1, 7'd20, 3'd5, 64, 10, 20, 25, 23, 5, 0, "post_abort");
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = $urandom_range(0, 9) == 0;
      brick_in = 19'($urandom);
      reset = $urandom_range(0, 299) == 0;
    end
    @(negedge clk);
    reset = 0;
    start = 0;
    repeat (80) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
